// File: rtl/bit_index_streamer_pkg.sv
// rtl/bit_index_streamer_pkg.sv - shared widths and FSM encodings for bit_index_streamer
package bit_index_streamer_pkg;

    localparam int BIS_WIDTH = 32;
    localparam int BIS_IDXW  = 5;
    localparam int BIS_CNTW  = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/bit_index_streamer_lsb_priority_enc.sv
// rtl/bit_index_streamer_lsb_priority_enc.sv - lowest-set-bit index with one-hot and zero flags
import bit_index_streamer_pkg::*;

module lsb_priority_enc #(
    parameter int WIDTH = BIS_WIDTH,
    parameter int IDXW  = BIS_IDXW
) (
    input  logic [WIDTH-1:0] shadow,
    output logic [IDXW-1:0]  index,
    output logic             onehot,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Scan from the top so the lowest set bit is the last assignment to win.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (shadow[i]) begin
                index = IDXW'(i);
            end
        end
    end

    assign zero   = ~|shadow;
    assign onehot = !zero && ((shadow & (shadow - ONE)) == '0);

endmodule

// File: rtl/bit_index_streamer.sv
// rtl/bit_index_streamer.sv - expands a word into a stream of set-bit indices, LSB first
import bit_index_streamer_pkg::*;

module bit_index_streamer #(
    parameter int WIDTH = BIS_WIDTH,
    parameter int IDXW  = BIS_IDXW,
    parameter int CNTW  = BIS_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic             done,
    output logic [CNTW-1:0]  done_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [CNTW-1:0]   done_count_q, done_count_d;

    logic [IDXW-1:0]   enc_index;
    logic              enc_onehot;
    logic              enc_zero;

    lsb_priority_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .shadow (shadow_q),
        .index  (enc_index),
        .onehot (enc_onehot),
        .zero   (enc_zero)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        count_d      = count_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        done_count_d = done_count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    shadow_d   = in_word;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    if (in_word != '0) begin
                        state_d     = S_EMIT;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d      = S_FIN;
                        done_d       = 1'b1;
                        done_count_d = '0;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready && !enc_zero) begin
                    shadow_d = shadow_q & ~(ONE << enc_index);
                    count_d  = count_q + CNTW'(1);
                    // done and its count are registered on the final beat so they appear in FIN.
                    if (enc_onehot) begin
                        state_d      = S_FIN;
                        out_valid_d  = 1'b0;
                        done_d       = 1'b1;
                        done_count_d = count_q + CNTW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            done_count_q <= done_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_index  = enc_index;
    assign out_last   = enc_onehot;
    assign done       = done_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_bit_index_streamer.sv
// tb/tb_bit_index_streamer.sv - directed self-checking bench for bit_index_streamer
module tb_bit_index_streamer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        done;
    logic [5:0]  done_count;

    int checks;
    int failures;

    bit_index_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_last   (out_last),
        .done       (done),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            in_valid = 1'b1;
            in_word  = w;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 5'd0 ||
            out_last !== 1'b0 || done !== 1'b0 || done_count !== 6'd0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b idx=%0d last=%b done=%b cnt=%0d, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_index, out_last, done, done_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_f000;
        int exp_idx [8] = '{12, 13, 14, 15, 28, 29, 30, 31};
        bit ok;
        out_ready = 1'b1;
        send(32'hF000F000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL f000_accept: in_ready never 1"); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_index !== 5'(exp_idx[i]) || out_last !== (i == 7)) begin
                failures++;
                $display("FAIL f000_beat%0d: vld=%b idx=%0d last=%b, want 1 %0d %0d",
                         i, out_valid, out_index, out_last, exp_idx[i], (i == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd8 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL f000_done: done=%b cnt=%0d vld=%b, want 1 8 0", done, done_count, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL f000_pulse: done=%b rdy=%b, want 0 1", done, in_ready);
        end
    endtask

    task automatic test_zero;
        bit ok;
        send(32'h0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_accept: in_ready never 1"); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%b cnt=%0d vld=%b rdy=%b, want 1 0 0 0",
                     done, done_count, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle: done=%b rdy=%b vld=%b, want 0 1 0", done, in_ready, out_valid);
        end
    endtask

    task automatic test_all_ones;
        bit ok;
        send(32'hFFFFFFFF, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ones_accept: in_ready never 1"); end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_index !== 5'(i) || out_last !== (i == 31)) begin
                failures++;
                $display("FAIL ones_beat%0d: vld=%b idx=%0d last=%b, want 1 %0d %0d",
                         i, out_valid, out_index, out_last, i, (i == 31));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd32) begin
            failures++;
            $display("FAIL ones_done: done=%b cnt=%0d, want 1 32", done, done_count);
        end
    endtask

    task automatic test_stall;
        bit ok;
        out_ready = 1'b0;
        send(32'h80000001, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_accept: in_ready never 1"); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_index !== 5'd0 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: vld=%b idx=%0d last=%b, want 1 0 0",
                         i, out_valid, out_index, out_last);
            end
            if (i == 3) out_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd31 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL stall_last: vld=%b idx=%0d last=%b, want 1 31 1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd2) begin
            failures++;
            $display("FAIL stall_done: done=%b cnt=%0d, want 1 2", done, done_count);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        bit saw_done;
        out_ready = 1'b1;
        send(32'h000000FF, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_accept: in_ready never 1"); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_index !== 5'(i)) begin
                failures++;
                $display("FAIL abort_beat%0d: vld=%b idx=%0d, want 1 %0d", i, out_valid, out_index, i);
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out_index !== 5'd0) begin
            failures++;
            $display("FAIL abort_async: vld=%b rdy=%b done=%b idx=%0d, want 0 1 0 0",
                     out_valid, in_ready, done, out_index);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abort_quiet: done/out_valid seen=1 after reset, want 0");
        end
        send(32'h00000010, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_next_accept: in_ready never 1"); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd4 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL abort_next_beat: vld=%b idx=%0d last=%b, want 1 4 1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd1) begin
            failures++;
            $display("FAIL abort_next_done: done=%b cnt=%0d, want 1 1", done, done_count);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        out_ready = 1'b1;
        send(32'h00000003, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_accept: in_ready never 1"); end
        in_valid = 1'b1;
        in_word  = 32'h00000100;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== 5'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL b2b_beat0: rdy=%b vld=%b idx=%0d last=%b, want 0 1 0 0",
                     in_ready, out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd1 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_beat1: vld=%b idx=%0d last=%b, want 1 1 1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd2 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: done=%b cnt=%0d vld=%b rdy=%b, want 1 2 0 0",
                     done, done_count, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd8 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: vld=%b idx=%0d last=%b, want 1 8 1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done_count !== 6'd1) begin
            failures++;
            $display("FAIL b2b_second_done: done=%b cnt=%0d, want 1 1", done, done_count);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        out_ready = 1'b1;
        test_reset();
        test_f000();
        test_zero();
        test_all_ones();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
